// File: rtl/butterfly2_inv.sv
// Inverse radix-2 butterfly: x0 = (y0+y1)/2, x1 = ((y0-y1)/2)*conj(w), one shared real multiplier.
// Build option: define BUTTERFLY2_INV_SAT_EN to saturate x1 instead of wrapping it.
//
// state | meaning
// IDLE  | o_ready high, waiting for operands
// SUM   | halved sum and difference computed
// M0    | accRe  = dr*wr
// M1    | accRe += di*wi
// M2    | accIm  = di*wr
// M3    | accIm -= dr*wi, result registered on exit
// OUT   | o_valid high until i_ready
module butterfly2_inv #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_in0_re,
  input  logic [N-1:0] i_in0_im,
  input  logic [N-1:0] i_in1_re,
  input  logic [N-1:0] i_in1_im,
  input  logic [N-1:0] i_twiddle_re,
  input  logic [N-1:0] i_twiddle_im,
  output logic [N-1:0] o_out0_re,
  output logic [N-1:0] o_out0_im,
  output logic [N-1:0] o_out1_re,
  output logic [N-1:0] o_out1_im,
  output logic         o_valid,
  input  logic         i_ready
);

  localparam int AW = 2*N + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUM  = 3'd1,
    S_M0   = 3'd2,
    S_M1   = 3'd3,
    S_M2   = 3'd4,
    S_M3   = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]          y0_re, y0_im, y1_re, y1_im, w_re, w_im;
  logic [N-1:0]          s_re, s_im, d_re, d_im;
  logic [N:0]            sum_re, sum_im, dif_re, dif_im;
  logic [N-1:0]          mul_a, mul_b;
  logic signed [2*N-1:0] prod;
  logic [AW-1:0]         prod_ext, acc_re, acc_im, acc_im_fin;
  logic [N-1:0]          x1_re, x1_im;
  logic                  unused_bits;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nx = S_SUM;
      end
      S_SUM: state_nx = S_M0;
      S_M0:  state_nx = S_M1;
      S_M1:  state_nx = S_M2;
      S_M2:  state_nx = S_M3;
      S_M3:  state_nx = S_OUT;
      S_OUT: begin
        o_valid = 1'b1;
        if (i_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // N+1-bit sum/difference; dropping bit 0 is the floor halving, so the result always fits N bits
  assign sum_re = {y0_re[N-1], y0_re} + {y1_re[N-1], y1_re};
  assign sum_im = {y0_im[N-1], y0_im} + {y1_im[N-1], y1_im};
  assign dif_re = {y0_re[N-1], y0_re} - {y1_re[N-1], y1_re};
  assign dif_im = {y0_im[N-1], y0_im} - {y1_im[N-1], y1_im};

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_M0: begin mul_a = d_re; mul_b = w_re; end
      S_M1: begin mul_a = d_im; mul_b = w_im; end
      S_M2: begin mul_a = d_im; mul_b = w_re; end
      S_M3: begin mul_a = d_re; mul_b = w_im; end
      default: ;
    endcase
  end

  assign prod       = $signed(mul_a) * $signed(mul_b);
  assign prod_ext   = {prod[2*N-1], prod};
  assign acc_im_fin = acc_im - prod_ext;

`ifdef BUTTERFLY2_INV_SAT_EN
  logic [N-Q+1:0] top_re, top_im;
  logic [N-1:0]   max_val, min_val;

  assign max_val = {1'b0, {(N-1){1'b1}}};
  assign min_val = {1'b1, {(N-1){1'b0}}};
  assign top_re  = acc_re[AW-1:Q+N-1];
  assign top_im  = acc_im_fin[AW-1:Q+N-1];

  // In range only when everything above the kept field is a copy of its sign bit
  assign x1_re = ((&top_re) || (~|top_re)) ? acc_re[Q+N-1:Q]
               : (acc_re[AW-1] ? min_val : max_val);
  assign x1_im = ((&top_im) || (~|top_im)) ? acc_im_fin[Q+N-1:Q]
               : (acc_im_fin[AW-1] ? min_val : max_val);

  assign unused_bits = ^{acc_re[Q-1:0], acc_im_fin[Q-1:0],
                         sum_re[0], sum_im[0], dif_re[0], dif_im[0]};
`else
  assign x1_re = acc_re[Q+N-1:Q];
  assign x1_im = acc_im_fin[Q+N-1:Q];

  assign unused_bits = ^{acc_re[AW-1:Q+N], acc_re[Q-1:0],
                         acc_im_fin[AW-1:Q+N], acc_im_fin[Q-1:0],
                         sum_re[0], sum_im[0], dif_re[0], dif_im[0]};
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      y0_re     <= '0;
      y0_im     <= '0;
      y1_re     <= '0;
      y1_im     <= '0;
      w_re      <= '0;
      w_im      <= '0;
      s_re      <= '0;
      s_im      <= '0;
      d_re      <= '0;
      d_im      <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      o_out0_re <= '0;
      o_out0_im <= '0;
      o_out1_re <= '0;
      o_out1_im <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            y0_re <= i_in0_re;
            y0_im <= i_in0_im;
            y1_re <= i_in1_re;
            y1_im <= i_in1_im;
            w_re  <= i_twiddle_re;
            w_im  <= i_twiddle_im;
          end
        end
        S_SUM: begin
          s_re <= sum_re[N:1];
          s_im <= sum_im[N:1];
          d_re <= dif_re[N:1];
          d_im <= dif_im[N:1];
        end
        S_M0: acc_re <= prod_ext;
        S_M1: acc_re <= acc_re + prod_ext;
        S_M2: acc_im <= prod_ext;
        S_M3: begin
          acc_im    <= acc_im_fin;
          o_out0_re <= s_re;
          o_out0_im <= s_im;
          o_out1_re <= x1_re;
          o_out1_im <= x1_im;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/butterfly2_inv.md
Name: butterfly2_inv

Overview:
Inverse radix-2 butterfly. It undoes the forward butterfly2 operation (out0 = x0 + w·x1, out1 = x0 − w·x1) for the IFFT path.
- Computes x0 = (y0 + y1)/2 and x1 = ((y0 − y1)/2)·conj(w), with w on the unit circle.
- Signed Q(N−Q).Q complex fixed point, same format as butterfly2.
- Shares one real multiplier over four cycles. Valid/ready handshake on both sides.

Parameters:
N, 16, total word width (signed two's complement)
Q, 8, fractional bits

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_valid  in  1  input operands valid
o_ready  out  1  block can accept operands (high only in IDLE)
i_in0_re / i_in0_im  in  N each  y0 real / imag
i_in1_re / i_in1_im  in  N each  y1 real / imag
i_twiddle_re / i_twiddle_im  in  N each  w real / imag (conjugate taken internally)
o_out0_re / o_out0_im  out  N each  x0 real / imag, registered
o_out1_re / o_out1_im  out  N each  x1 real / imag, registered
o_valid  out  1  outputs valid; held until i_ready
i_ready  in  1  downstream accepts outputs

Behaviour:
- Reset (i_rst = 0, asynchronous): state IDLE, all outputs and internal registers 0, o_valid = 0, o_ready = 1 once released.
- Reset asserted mid-operation aborts the operation; no partial result is presented.
- States: IDLE → SUM → M0 → M1 → M2 → M3 → OUT → IDLE.
- IDLE: o_ready = 1. On an edge with i_valid = 1, register all six operand words and go to SUM.
- SUM: compute N+1-bit sum and difference; arithmetic right shift by 1 (floor).
  - s = (y0 + y1) >>> 1 and d = (y0 − y1) >>> 1, each real/imag.
  - Always fits in N bits, no overflow.
  - Register s into o_out0_* only at the OUT transition. Until then o_out0_* hold the previous result.
- M0..M3: one signed N×N product per state, accumulated in 2N+1-bit accumulators.
  - M0: accRe = dr·wr
  - M1: accRe += di·wi
  - M2: accIm = di·wr
  - M3: accIm −= dr·wi
- End of M3 (transition to OUT):
  - o_out1_re = accRe[Q+N−1:Q], o_out1_im = accIm[Q+N−1:Q]; truncation (floor), wrap on overflow.
  - o_out0_* = s.
  - o_valid set.
- OUT: o_valid = 1, o_ready = 0, outputs stable. When i_ready = 1 at an edge, clear o_valid and go to IDLE. Output data registers keep their values.
- Latency: operands accepted at edge k → o_valid high after edge k+5. Minimum issue interval is 7 cycles with i_ready tied high.
- i_valid while o_ready = 0 is ignored; the operands are not queued.
- Operand changes after acceptance have no effect.
- i_ready outside OUT is ignored.

Optional Feature:
- Macro BUTTERFLY2_INV_SAT_EN.
- Defined: o_out1_re/im saturate to [−2^(N−1), 2^(N−1)−1] when accumulator bits above Q+N−1 are not a sign extension of the result. Saturation adds no latency.
- Undefined: plain wraparound truncation as above.
- o_out0_* never saturate (cannot overflow).

Test Plan:
1. y0 = (0x0500, 0x0000), y1 = (0xFF00, 0x0200), w = (0x0100, 0x0000), i_ready = 1 → o_out0 = (0x0200, 0x0100), o_out1 = (0x0300, 0xFF00). o_valid rises 5 cycles after acceptance and is high exactly 1 cycle.
2. y0 = (0x0100, 0xFE00), y1 = (0x0300, 0x0400), w = (0x0000, 0xFF00) → o_out0 = (0x0200, 0x0100), o_out1 = (0x0300, 0xFF00). Exercises the conjugate/imaginary path.
3. Rounding:
   - y0 = (0x0001, 0), y1 = 0, w = (0x0100, 0) → o_out0_re = 0x0000.
   - y0 = (0xFFFF, 0) → o_out0_re = 0xFFFF, o_out1_re = 0xFFFF.
4. Overflow: y0 = (0x7FFF, 0), y1 = (0x8000, 0), w = (0x0200, 0) → o_out0_re = 0xFFFF, o_out1_im = 0.
   - Without BUTTERFLY2_INV_SAT_EN: o_out1_re = 0xFFFE.
   - With BUTTERFLY2_INV_SAT_EN: o_out1_re = 0x7FFF.
5. Handshake:
   - i_ready = 0 for 4 cycles in OUT → outputs and o_valid held, o_ready = 0.
   - Second i_valid pulse during M1 ignored.
   - i_ready = 1 → o_ready = 1 on the next cycle.
6. Assert i_rst = 0 during M2 → all outputs 0 immediately (asynchronous), o_valid = 0. After release, a fresh scenario-1 transaction completes correctly.
